tlb_op_unit: RTL and testbench
==============================

TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 The module SHALL have parameter TLB_ENTRIES, default 16, giving the number of TLB entries; the index width IW is $clog2(TLB_ENTRIES).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port op_valid, input, 1 bit: the pipeline requests a TLB instruction.
REQ-005 The module SHALL have port op_type, input, 2 bits: 0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP.
REQ-006 The module SHALL have port op_ready, output, 1 bit: the unit can accept an op.
REQ-007 The module SHALL have port flush, input, 1 bit: exception or ERET kill.
REQ-008 The module SHALL have ports entryhi_i, entrylo0_i and entrylo1_i, inputs, 32 bits each: current CP0 values.
REQ-009 The module SHALL have port index_i, input, 32 bits: the CP0 Index register.
REQ-010 The module SHALL have port wired_i, input, IW bits: the CP0 Wired register.
REQ-011 The module SHALL have port wired_we, input, 1 bit: Wired is being written this cycle.
REQ-012 The module SHALL have port tlbw_valid, output, 1 bit; port tlbw_addr, output, IW bits; and port tlbw_data, output, tlb_entry_t: the TLB write port.
REQ-013 The module SHALL have port tlbra, output, IW bits (TLB read address) and port tlbrd, input, tlb_entry_t (TLB read data).
REQ-014 The module SHALL have port tlbp_index, input, cp0_index_t: the TLB probe result for entryhi_i.
REQ-015 The module SHALL have port done_valid, output, 1 bit, and port done_type, output, 2 bits: the op completed.
REQ-016 The module SHALL have ports entryhi_o, entrylo0_o, entrylo1_o and index_o, outputs, 32 bits each: CP0 write-back values.
REQ-017 The module SHALL have port random_o, output, IW bits: the CP0 Random register.

Function
REQ-018 The FSM SHALL have the states IDLE, EXEC and DONE; op_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, op_valid&&!flush SHALL latch op_type, the inputs, the target address (TLBWR: random_o; otherwise index_i[IW-1:0]) and move to EXEC.
REQ-020 In EXEC, TLBWI/TLBWR SHALL assert tlbw_valid for exactly that one cycle, with tlbw_data built from the latched EntryHi VPN2/ASID, G=lo0.G&lo1.G, and PFN/C/D/V per EntryLo.
REQ-021 In EXEC, TLBR SHALL drive tlbra=latched index and capture tlbrd; TLBP SHALL capture tlbp_index.
REQ-022 EXEC SHALL always go to DONE; DONE SHALL pulse done_valid=1 with done_type=latched op and return to IDLE, giving 2-cycle accept-to-done latency.
REQ-023 For TLBR done, entryhi_o={VPN2,5'b0,ASID}, and entrylo0_o/entrylo1_o={6'b0,PFN,C,D,V,G}; for TLBP done, index_o={P,zero,index}; all other done types SHALL leave these outputs at their previous values.
REQ-024 tlbw_valid SHALL be 0 outside EXEC; tlbra SHALL hold its latched value outside EXEC.
REQ-025 A flush in EXEC SHALL suppress tlbw_valid, go to IDLE and produce no done_valid; a flush in DONE SHALL suppress done_valid.
REQ-026 random_o SHALL decrement every cycle, and SHALL load TLB_ENTRIES-1 when it equals wired_i or when wired_we=1 (wired_we has priority).
REQ-027 If wired_i equals TLB_ENTRIES-1, random_o SHALL stay at TLB_ENTRIES-1.
REQ-028 If wired_i exceeds random_o, random_o SHALL decrement to 0 and wrap to TLB_ENTRIES-1.
REQ-029 TLBWR SHALL use the random_o value sampled in the accept cycle.
REQ-030 op_valid while op_ready=0 SHALL be ignored; the pipeline SHALL hold the op until accepted.

Reset
REQ-031 Asserting resetn low SHALL immediately force: state=IDLE, tlbw_valid=0, done_valid=0, done_type=0, tlbra=0, tlbw_addr=0, tlbw_data=0, entryhi_o/entrylo0_o/entrylo1_o/index_o=0, random_o=TLB_ENTRIES-1.
REQ-032 A reset mid-op SHALL abort the op with no TLB write.

Structure
REQ-033 tlb_entry_t, cp0_index_t, the op_type encodings and TLB_ENTRIES SHALL reside in the shared pipeline package.
REQ-034 The Random counter SHALL be a sub-module, tlb_random.

Verification
REQ-035 Verification SHALL cover: TLBWI with index_i=5, entryhi_i=0x00402011, lo0=0x00000017, lo1=0x00000057 -> tlbw_valid=1 one cycle later with addr 5 and G=1; done_valid at +2.
REQ-036 Verification SHALL cover: TLBP where tlbp_index.P=1 -> index_o=0x80000000; where the probe hits entry 3 -> index_o=3.
REQ-037 Verification SHALL cover: TLBR of entry 7 holding VPN2=0x1234, ASID=0x5A -> entryhi_o=0x0246805A.
REQ-038 Verification SHALL cover: wired_i=4 from reset -> random_o sequence 15,14,...,5,4,15.
REQ-039 Verification SHALL cover: TLBWR accepted when random_o=9 -> tlbw_addr=9 even though random_o has changed since.
REQ-040 Verification SHALL cover: flush in the EXEC cycle of TLBWI -> no tlbw_valid, no done_valid, op_ready=1 on the next cycle.

Source files
------------

// File: rtl/tlb_op_unit_pkg.sv
// rtl/tlb_op_unit_pkg.sv - shared TLB types, op encodings and TLB size
package tlb_op_unit_pkg;

    localparam int TLB_ENTRIES = 16;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_e;

    // One half of a TLB entry: the even or odd physical page
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    // Probe result in CP0 Index layout; only the low index bits are meaningful
    typedef struct packed {
        logic        p;
        logic [30:0] index;
    } cp0_index_t;

    // Rebuild an EntryLo word from one page of an entry plus the shared G bit
    function automatic logic [31:0] page_to_lo(input tlb_page_t pg, input logic g);
        return {6'b0, pg.pfn, pg.c, pg.d, pg.v, g};
    endfunction

endpackage

// File: rtl/tlb_random.sv
// rtl/tlb_random.sv - CP0 Random register, free-running down-counter bounded by Wired
module tlb_random #(
    parameter int TLB_ENTRIES = 16,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [IW-1:0] wired_i,
    input  logic          wired_we,
    output logic [IW-1:0] random_o
);

    localparam logic [IW-1:0] TOP = IW'(TLB_ENTRIES - 1);

    logic [IW-1:0] random_q;
    logic [IW-1:0] random_d;

    // Count down each cycle; reload the top on a Wired write, on reaching Wired, or below 0
    always_comb begin
        random_d = random_q - IW'(1);
        if (wired_we || (random_q == wired_i) || (random_q == '0)) begin
            random_d = TOP;
        end
    end

    // Random register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - executes TLBR/TLBWI/TLBWR/TLBP with a 2-cycle accept-to-done sequence
module tlb_op_unit
    import tlb_op_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = tlb_op_unit_pkg::TLB_ENTRIES,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    input  logic          flush,
    input  logic [31:0]   entryhi_i,
    input  logic [31:0]   entrylo0_i,
    input  logic [31:0]   entrylo1_i,
    input  logic [31:0]   index_i,
    input  logic [IW-1:0] wired_i,
    input  logic          wired_we,
    output logic          tlbw_valid,
    output logic [IW-1:0] tlbw_addr,
    output tlb_entry_t    tlbw_data,
    output logic [IW-1:0] tlbra,
    input  tlb_entry_t    tlbrd,
    input  cp0_index_t    tlbp_index,
    output logic          done_valid,
    output logic [1:0]    done_type,
    output logic [31:0]   entryhi_o,
    output logic [31:0]   entrylo0_o,
    output logic [31:0]   entrylo1_o,
    output logic [31:0]   index_o,
    output logic [IW-1:0] random_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    tlb_op_e       op_q;
    logic [IW-1:0] addr_q;
    tlb_entry_t    wdata_q;
    tlb_entry_t    wdata_d;
    tlb_entry_t    rd_q;
    cp0_index_t    probe_q;
    logic [31:0]   entryhi_q, entrylo0_q, entrylo1_q, index_q;
    logic          accept;
    logic          is_write;
    logic [IW-1:0] random_w;
    logic          unused_bits;

    tlb_random #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired_i  (wired_i),
        .wired_we (wired_we),
        .random_o (random_w)
    );

    assign is_write = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);

    // Reserved CP0 fields and high Index bits carry no information for the TLB
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26],
                           index_i[31:IW], tlbp_index.index[30:IW]};

    // Next state and the ready/write/done strobes; a flush kills whatever is in flight
    always_comb begin
        state_d    = state_q;
        op_ready   = 1'b0;
        tlbw_valid = 1'b0;
        done_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                tlbw_valid = is_write && !flush;
                state_d    = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_valid = !flush;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Assemble the entry to write from the live CP0 values; G is the AND of both halves
    always_comb begin
        wdata_d         = '0;
        wdata_d.vpn2    = entryhi_i[31:13];
        wdata_d.asid    = entryhi_i[7:0];
        wdata_d.g       = entrylo0_i[0] & entrylo1_i[0];
        wdata_d.p0.pfn  = entrylo0_i[25:6];
        wdata_d.p0.c    = entrylo0_i[5:3];
        wdata_d.p0.d    = entrylo0_i[2];
        wdata_d.p0.v    = entrylo0_i[1];
        wdata_d.p1.pfn  = entrylo1_i[25:6];
        wdata_d.p1.c    = entrylo1_i[5:3];
        wdata_d.p1.d    = entrylo1_i[2];
        wdata_d.p1.v    = entrylo1_i[1];
    end

    // Latch the op, its target slot and write data at accept; TLBWR takes Random as it is now
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= OP_TLBR;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= tlb_op_e'(op_type);
            addr_q  <= (tlb_op_e'(op_type) == OP_TLBWR) ? random_w : index_i[IW-1:0];
            wdata_q <= wdata_d;
        end
    end

    // Capture TLB read data or probe result during the execute cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q    <= '0;
            probe_q <= '0;
        end else if ((state_q == S_EXEC) && !flush) begin
            if (op_q == OP_TLBR) begin
                rd_q <= tlbrd;
            end
            if (op_q == OP_TLBP) begin
                probe_q <= tlbp_index;
            end
        end
    end

    // Commit CP0 write-back values only when the op actually completes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            index_q    <= '0;
        end else if (done_valid) begin
            if (op_q == OP_TLBR) begin
                entryhi_q  <= {rd_q.vpn2, 5'b0, rd_q.asid};
                entrylo0_q <= page_to_lo(rd_q.p0, rd_q.g);
                entrylo1_q <= page_to_lo(rd_q.p1, rd_q.g);
            end
            if (op_q == OP_TLBP) begin
                index_q <= {probe_q.p, {(31 - IW){1'b0}}, probe_q.index[IW-1:0]};
            end
        end
    end

    assign tlbw_addr  = addr_q;
    assign tlbw_data  = wdata_q;
    assign tlbra      = addr_q;
    assign done_type  = op_q;
    assign entryhi_o  = entryhi_q;
    assign entrylo0_o = entrylo0_q;
    assign entrylo1_o = entrylo1_q;
    assign index_o    = index_q;
    assign random_o   = random_w;

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - randomized self-checking bench for tlb_op_unit
module tb_tlb_op_unit;
    import tlb_op_unit_pkg::*;

    localparam int N = 16;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_type;
    logic        op_ready;
    logic        flush;
    logic [31:0] entryhi_i, entrylo0_i, entrylo1_i, index_i;
    logic [3:0]  wired_i;
    logic        wired_we;
    logic        tlbw_valid;
    logic [3:0]  tlbw_addr;
    tlb_entry_t  tlbw_data;
    logic [3:0]  tlbra;
    tlb_entry_t  tlbrd;
    cp0_index_t  tlbp_index;
    logic        done_valid;
    logic [1:0]  done_type;
    logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, index_o;
    logic [3:0]  random_o;

    tlb_entry_t tlb_mem [N];
    assign tlbrd = tlb_mem[tlbra];

    int n_checks = 0;
    int n_err    = 0;

    tlb_op_unit #(.TLB_ENTRIES(N)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .flush(flush), .entryhi_i(entryhi_i),
        .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i), .index_i(index_i),
        .wired_i(wired_i), .wired_we(wired_we), .tlbw_valid(tlbw_valid),
        .tlbw_addr(tlbw_addr), .tlbw_data(tlbw_data), .tlbra(tlbra), .tlbrd(tlbrd),
        .tlbp_index(tlbp_index), .done_valid(done_valid), .done_type(done_type),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
        .index_o(index_o), .random_o(random_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference view of the architecture: words in, words out
    function automatic tlb_entry_t exp_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                             input logic [31:0] lo1);
        tlb_entry_t e;
        e.vpn2   = 19'(hi / 8192);
        e.asid   = 8'(hi % 256);
        e.g      = 1'(lo0 % 2) & 1'(lo1 % 2);
        e.p0.pfn = 20'((lo0 / 64) % 1048576);
        e.p0.c   = 3'((lo0 / 8) % 8);
        e.p0.d   = 1'((lo0 / 4) % 2);
        e.p0.v   = 1'((lo0 / 2) % 2);
        e.p1.pfn = 20'((lo1 / 64) % 1048576);
        e.p1.c   = 3'((lo1 / 8) % 8);
        e.p1.d   = 1'((lo1 / 4) % 2);
        e.p1.v   = 1'((lo1 / 2) % 2);
        return e;
    endfunction

    function automatic logic [31:0] hi_word(input tlb_entry_t e);
        return 32'(e.vpn2) * 8192 + 32'(e.asid);
    endfunction

    function automatic logic [31:0] lo_word(input tlb_page_t p, input logic g);
        return 32'(p.pfn) * 64 + 32'(p.c) * 8 + 32'(p.d) * 4 + 32'(p.v) * 2 + 32'(g);
    endfunction

    // Model state: at most one op in flight, tracked by the cycle it was accepted in
    int          cyc;
    bit          m_busy;
    int          m_acc;
    int          m_op;
    int          m_addr;
    int          m_last_addr;
    int          m_rand;
    tlb_entry_t  m_ent;
    tlb_entry_t  m_rd;
    cp0_index_t  m_pr;
    logic [31:0] m_hi, m_lo0, m_lo1, m_idx;

    task automatic model_reset();
        cyc = 0; m_busy = 0; m_acc = 0; m_op = 0; m_addr = 0; m_last_addr = 0;
        m_rand = N - 1; m_ent = '0; m_rd = '0; m_pr = '0;
        m_hi = '0; m_lo0 = '0; m_lo1 = '0; m_idx = '0;
    endtask

    always @(negedge clk) begin : mdl
        int age;
        bit exec, done, wr, wv;
        if (!resetn) begin
            model_reset();
        end else begin
            age  = m_busy ? cyc - m_acc : 0;
            exec = m_busy && (age == 1);
            done = m_busy && (age == 2);
            wr   = (m_op == 1) || (m_op == 2);
            wv   = exec && wr && !flush;
            chk("op_ready", 128'(op_ready), 128'(!m_busy));
            chk("tlbw_valid", 128'(tlbw_valid), 128'(wv));
            if (wv) begin
                chk("tlbw_addr", 128'(tlbw_addr), 128'(m_addr));
                chk("tlbw_data", 128'(tlbw_data), 128'(m_ent));
            end
            chk("done_valid", 128'(done_valid), 128'(done && !flush));
            if (done && !flush) chk("done_type", 128'(done_type), 128'(m_op));
            chk("tlbra", 128'(tlbra), 128'(m_last_addr));
            chk("random_o", 128'(random_o), 128'(m_rand));
            chk("entryhi_o", 128'(entryhi_o), 128'(m_hi));
            chk("entrylo0_o", 128'(entrylo0_o), 128'(m_lo0));
            chk("entrylo1_o", 128'(entrylo1_o), 128'(m_lo1));
            chk("index_o", 128'(index_o), 128'(m_idx));

            if (exec) begin
                if (flush) m_busy = 0;
                else if (m_op == 0) m_rd = tlb_mem[m_addr];
                else if (m_op == 3) m_pr = tlbp_index;
            end else if (done) begin
                m_busy = 0;
                if (!flush && m_op == 0) begin
                    m_hi  = hi_word(m_rd);
                    m_lo0 = lo_word(m_rd.p0, m_rd.g);
                    m_lo1 = lo_word(m_rd.p1, m_rd.g);
                end
                if (!flush && m_op == 3) m_idx = (m_pr.p ? 32'h8000_0000 : 32'h0) + 32'(m_pr.index % N);
            end else if (op_valid && !flush) begin
                m_busy      = 1;
                m_acc       = cyc;
                m_op        = int'(op_type);
                m_addr      = (op_type == 2'd2) ? m_rand : int'(index_i % N);
                m_last_addr = m_addr;
                m_ent       = exp_entry(entryhi_i, entrylo0_i, entrylo1_i);
            end

            if (wired_we || m_rand == int'(wired_i)) m_rand = N - 1;
            else if (m_rand == 0) m_rand = N - 1;
            else m_rand = m_rand - 1;
            cyc++;
        end
    end

    // Issue one op from idle; report what was seen in its exec and done cycles
    task automatic do_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1, input cp0_index_t pr,
                         input int fl, output bit w_v, output logic [3:0] w_a,
                         output tlb_entry_t w_d, output bit d_v, output logic [1:0] d_t,
                         output bit d_r);
        @(posedge clk); #1;
        op_valid = 1; op_type = op; index_i = idx; entryhi_i = hi;
        entrylo0_i = lo0; entrylo1_i = lo1; tlbp_index = pr;
        @(posedge clk); #1;
        op_valid = 0; flush = (fl == 1);
        @(negedge clk);
        w_v = tlbw_valid; w_a = tlbw_addr; w_d = tlbw_data;
        @(posedge clk); #1;
        flush = (fl == 2);
        @(negedge clk);
        d_v = done_valid; d_t = done_type; d_r = op_ready;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [95:0] tmp;
        bit          w_v, d_v, d_r, acc, found;
        logic [3:0]  w_a;
        tlb_entry_t  w_d;
        logic [1:0]  d_t;

        resetn = 0; op_valid = 0; op_type = 0; flush = 0;
        entryhi_i = 0; entrylo0_i = 0; entrylo1_i = 0; index_i = 0;
        wired_i = 4; wired_we = 0; tlbp_index = '0;
        for (int i = 0; i < N; i++) begin
            tmp = {$urandom(), $urandom(), $urandom()};
            tlb_mem[i] = tmp[$bits(tlb_entry_t)-1:0];
        end
        tlb_mem[7] = '0;
        tlb_mem[7].vpn2 = 19'h1234; tlb_mem[7].asid = 8'h5A; tlb_mem[7].g = 1'b1;
        tlb_mem[7].p0.pfn = 20'hABCDE; tlb_mem[7].p0.c = 3'd3; tlb_mem[7].p0.d = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", 128'(op_ready), 128'(1));
        chk("rst_tlbw_valid", 128'(tlbw_valid), 128'(0));
        chk("rst_done_valid", 128'(done_valid), 128'(0));
        chk("rst_done_type", 128'(done_type), 128'(0));
        chk("rst_tlbra", 128'(tlbra), 128'(0));
        chk("rst_tlbw_addr", 128'(tlbw_addr), 128'(0));
        chk("rst_tlbw_data", 128'(tlbw_data), 128'(0));
        chk("rst_entryhi", 128'(entryhi_o), 128'(0));
        chk("rst_index", 128'(index_o), 128'(0));
        chk("rst_random", 128'(random_o), 128'(15));
        @(posedge clk); #1;
        resetn = 1;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("random_seq", 128'(random_o), 128'((k < 12) ? 15 - k : 15));
        end

        do_op(2'd1, 32'd5, 32'h0040_2011, 32'h17, 32'h57, '0, 0, w_v, w_a, w_d, d_v, d_t, d_r);
        chk("tlbwi_valid", 128'(w_v), 128'(1));
        chk("tlbwi_addr", 128'(w_a), 128'(5));
        chk("tlbwi_g", 128'(w_d.g), 128'(1));
        chk("tlbwi_vpn2", 128'(w_d.vpn2), 128'(19'h201));
        chk("tlbwi_asid", 128'(w_d.asid), 128'(8'h11));
        chk("tlbwi_p0c", 128'(w_d.p0.c), 128'(2));
        chk("tlbwi_p1pfn", 128'(w_d.p1.pfn), 128'(1));
        chk("tlbwi_done", 128'(d_v), 128'(1));
        chk("tlbwi_done_type", 128'(d_t), 128'(1));
        chk("tlbwi_busy_in_done", 128'(d_r), 128'(0));

        do_op(2'd0, 32'd7, 32'h0, 32'h0, 32'h0, '0, 0, w_v, w_a, w_d, d_v, d_t, d_r);
        chk("tlbr_no_write", 128'(w_v), 128'(0));
        chk("tlbr_done_type", 128'(d_t), 128'(0));
        chk("tlbr_entryhi", 128'(entryhi_o), 128'(32'h0246_805A));
        chk("tlbr_entrylo0", 128'(entrylo0_o), 128'(32'h02AF_379D));
        chk("tlbr_entrylo1", 128'(entrylo1_o), 128'(32'h1));

        do_op(2'd3, 32'd0, 32'h0, 32'h0, 32'h0, '{p: 1'b1, index: 31'd0}, 0,
              w_v, w_a, w_d, d_v, d_t, d_r);
        chk("tlbp_miss", 128'(index_o), 128'(32'h8000_0000));
        do_op(2'd3, 32'd0, 32'h0, 32'h0, 32'h0, '{p: 1'b0, index: 31'd3}, 0,
              w_v, w_a, w_d, d_v, d_t, d_r);
        chk("tlbp_hit", 128'(index_o), 128'(3));

        do_op(2'd1, 32'd6, $urandom(), $urandom(), $urandom(), '0, 1, w_v, w_a, w_d, d_v, d_t, d_r);
        chk("flush_exec_write", 128'(w_v), 128'(0));
        chk("flush_exec_done", 128'(d_v), 128'(0));
        chk("flush_exec_ready", 128'(d_r), 128'(1));

        do_op(2'd3, 32'd0, 32'h0, 32'h0, 32'h0, '{p: 1'b0, index: 31'd9}, 2,
              w_v, w_a, w_d, d_v, d_t, d_r);
        chk("flush_done_valid", 128'(d_v), 128'(0));
        chk("flush_done_index", 128'(index_o), 128'(3));

        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (random_o == 4'd9) found = 1;
        end
        chk("tlbwr_found_random9", 128'(found), 128'(1));
        if (found) begin
            op_valid = 1; op_type = 2'd2; index_i = 32'd1;
            entryhi_i = $urandom(); entrylo0_i = $urandom(); entrylo1_i = $urandom();
            @(posedge clk); #1;
            op_valid = 0;
            @(negedge clk);
            chk("tlbwr_valid", 128'(tlbw_valid), 128'(1));
            chk("tlbwr_addr", 128'(tlbw_addr), 128'(9));
            chk("tlbwr_random_moved", 128'(random_o), 128'(8));
            repeat (3) @(negedge clk);
        end

        @(posedge clk); #1;
        op_valid = 1; op_type = 2'd1; index_i = 32'd2;
        @(posedge clk); #1;
        op_valid = 0;
        resetn = 0;
        #1;
        chk("midop_rst_write", 128'(tlbw_valid), 128'(0));
        chk("midop_rst_ready", 128'(op_ready), 128'(1));
        chk("midop_rst_random", 128'(random_o), 128'(15));
        chk("midop_rst_entryhi", 128'(entryhi_o), 128'(0));
        chk("midop_rst_tlbra", 128'(tlbra), 128'(0));
        @(posedge clk); #1;
        resetn = 1;
        @(negedge clk);
        chk("midop_rst_no_write", 128'(tlbw_valid), 128'(0));
        @(negedge clk);
        chk("midop_rst_no_done", 128'(done_valid), 128'(0));

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc = op_valid && op_ready && !flush;
            @(posedge clk); #1;
            if (!op_valid || acc) begin
                op_valid   = ($urandom_range(0, 2) != 0);
                op_type    = 2'($urandom_range(0, 3));
                index_i    = $urandom();
                entryhi_i  = $urandom();
                entrylo0_i = $urandom();
                entrylo1_i = $urandom();
            end
            flush    = ($urandom_range(0, 7) == 0);
            wired_we = ($urandom_range(0, 15) == 0);
            if (wired_we) wired_i = 4'($urandom_range(0, 15));
            tlbp_index.p     = 1'($urandom_range(0, 1));
            tlbp_index.index = 31'($urandom_range(0, 15));
        end

        @(posedge clk); #1;
        op_valid = 0; flush = 0; wired_we = 0;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
